// File: rtl/lcd_read_if.sv
// Request/response and LCD bus signals of the KS0108 read controller.
// master: requesting logic plus panel/bus owner; slave: lcd_read_ctrl.
interface lcd_read_if;
    logic       req;
    logic       req_type;
    logic [1:0] req_cs;
    logic [2:0] req_page;
    logic [5:0] req_col;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rd_data;
    logic       bus_req;
    logic       bus_gnt;
    logic       lcd_di;
    logic       lcd_rw;
    logic       lcd_en;
    logic [1:0] lcd_cs;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [7:0] lcd_data_in;

    modport master (
        output req, req_type, req_cs, req_page, req_col, bus_gnt, lcd_data_in,
        input  busy, done, err, rd_data, bus_req,
        input  lcd_di, lcd_rw, lcd_en, lcd_cs, lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  req, req_type, req_cs, req_page, req_col, bus_gnt, lcd_data_in,
        output busy, done, err, rd_data, bus_req,
        output lcd_di, lcd_rw, lcd_en, lcd_cs, lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_read_ctrl.sv
// Status / display-data reads on a KS0108-style two-chip panel; all outputs are registered.
// Define BUSY_POLL_EN to poll the busy flag before each instruction write (with timeout).
module lcd_read_ctrl #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned EN_HIGH_CYC = 1,
    parameter int unsigned EN_LOW_CYC  = 1
`ifdef BUSY_POLL_EN
    ,
    parameter int unsigned BUSY_TIMEOUT = 255
`endif
) (
    input logic       clk,
    input logic       rst,
    lcd_read_if.slave lcd
);

    typedef enum logic [2:0] {
        StIdle, StErr, StWaitGnt, StSetup, StEnHi, StEnLo, StDone, StAbort
    } state_e;

    typedef enum logic [2:0] {
        StepStat, StepPollPage, StepPage, StepPollCol, StepCol, StepDummy, StepData
    } step_e;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       bus_req;
        logic       di;
        logic       rw;
        logic       en;
        logic [1:0] cs;
        logic [7:0] dout;
        logic       oe;
    } out_t;

    localparam logic [15:0] SetupLast = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EnHiLast  = 16'(EN_HIGH_CYC - 1);
    localparam logic [15:0] EnLoLast  = 16'(EN_LOW_CYC - 1);
`ifdef BUSY_POLL_EN
    localparam logic [15:0] PollLast  = 16'(BUSY_TIMEOUT - 1);
    localparam step_e       FirstData = StepPollPage;
    localparam step_e       AfterPage = StepPollCol;
`else
    localparam step_e       FirstData = StepPage;
    localparam step_e       AfterPage = StepCol;
`endif

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cs_q;
    logic [2:0]  page_q;
    logic [5:0]  col_q;
    logic [7:0]  data_q, rd_data_q, instr_byte;
    logic        accept, capture, is_read;
    out_t        out_d, out_q;

    assign is_read = (step_q != StepPage) && (step_q != StepCol);
    // Pad data is taken on the edge that ends the visible enable-high phase.
    assign capture = (state_q == StEnLo) && (cnt_q == '0) && is_read;

    always_comb begin
        instr_byte = 8'h00;
        if (step_q == StepPage) begin
            instr_byte = {5'b10111, page_q};
        end else if (step_q == StepCol) begin
            instr_byte = {2'b01, col_q};
        end
    end

`ifdef BUSY_POLL_EN
    logic [15:0] poll_q, poll_d;
    logic [7:0]  rd_byte;
    assign rd_byte = (cnt_q == '0) ? lcd.lcd_data_in : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
`ifdef BUSY_POLL_EN
        poll_d  = poll_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (lcd.req && !out_q.busy) begin
                    if (lcd.req_cs == 2'b01 || lcd.req_cs == 2'b10) begin
                        state_d = StWaitGnt;
                        accept  = 1'b1;
                        step_d  = lcd.req_type ? FirstData : StepStat;
`ifdef BUSY_POLL_EN
                        poll_d  = '0;
`endif
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StWaitGnt: begin
                if (lcd.bus_gnt) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                end
            end
            StSetup: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == SetupLast) begin
                    state_d = StEnHi;
                    cnt_d   = '0;
                end
            end
            StEnHi: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == EnHiLast) begin
                    state_d = StEnLo;
                    cnt_d   = '0;
                end
            end
            StEnLo: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == EnLoLast) begin
                    cnt_d   = '0;
                    state_d = StSetup;
                    unique case (step_q)
                        StepStat, StepData: state_d = StDone;
                        StepPage:           step_d  = AfterPage;
                        StepCol:            step_d  = StepDummy;
                        StepDummy:          step_d  = StepData;
                        default: begin
`ifdef BUSY_POLL_EN
                            if (!rd_byte[7]) begin
                                step_d = (step_q == StepPollPage) ? StepPage : StepCol;
                                poll_d = '0;
                            end else if (poll_q == PollLast) begin
                                state_d = StAbort;
                            end else begin
                                poll_d = poll_q + 16'd1;
                            end
`else
                            state_d = StIdle;
`endif
                        end
                    endcase
                end
            end
            StDone, StErr, StAbort: state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d = '0;
        unique case (state_q)
            StWaitGnt: begin
                out_d.busy    = 1'b1;
                out_d.bus_req = 1'b1;
            end
            StSetup, StEnHi, StEnLo: begin
                out_d.busy    = 1'b1;
                out_d.bus_req = 1'b1;
                out_d.cs      = cs_q;
                out_d.en      = (state_q == StEnHi);
                out_d.rw      = is_read;
                out_d.oe      = !is_read;
                out_d.di      = (step_q == StepDummy) || (step_q == StepData);
                out_d.dout    = instr_byte;
            end
            StDone: begin
                out_d.busy    = 1'b1;
                out_d.bus_req = 1'b1;
                out_d.done    = 1'b1;
                out_d.cs      = cs_q;
            end
            StAbort: begin
                out_d.busy    = 1'b1;
                out_d.bus_req = 1'b1;
                out_d.done    = 1'b1;
                out_d.err     = 1'b1;
            end
            StErr: begin
                out_d.done = 1'b1;
                out_d.err  = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= StepStat;
            cnt_q     <= '0;
            cs_q      <= '0;
            page_q    <= '0;
            col_q     <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            out_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            if (accept) begin
                cs_q   <= lcd.req_cs;
                page_q <= lcd.req_page;
                col_q  <= lcd.req_col;
            end
            if (capture) begin
                data_q <= lcd.lcd_data_in;
            end
            if (state_q == StDone) begin
                rd_data_q <= data_q;
            end
        end
    end

    assign lcd.busy         = out_q.busy;
    assign lcd.done         = out_q.done;
    assign lcd.err          = out_q.err;
    assign lcd.bus_req      = out_q.bus_req;
    assign lcd.lcd_di       = out_q.di;
    assign lcd.lcd_rw       = out_q.rw;
    assign lcd.lcd_en       = out_q.en;
    assign lcd.lcd_cs       = out_q.cs;
    assign lcd.lcd_data_out = out_q.dout;
    assign lcd.lcd_data_oe  = out_q.oe;
    assign lcd.rd_data      = rd_data_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Randomized bench for lcd_read_ctrl: a panel model answers reads, and each request is
// checked against its expected bus-cycle list, completion time and returned byte.
`timescale 1ns/1ps
module tb_lcd_read_ctrl;

    typedef struct packed {
        logic       di;
        logic       rw;
        logic [1:0] cs;
        logic       oe;
        logic [7:0] dout;
    } bus_cyc_t;

`ifdef BUSY_POLL_EN
    localparam int BusyTimeout = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_rd;
    logic [7:0] resp_q[$];
    bus_cyc_t   obs_q[$];
    int         en_cyc_q[$];

    lcd_read_if lif ();

    lcd_read_ctrl #(
        .SETUP_CYC  (1),
        .EN_HIGH_CYC(1),
        .EN_LOW_CYC (1)
`ifdef BUSY_POLL_EN
        ,
        .BUSY_TIMEOUT(BusyTimeout)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd(lif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bus_cyc_t mk(input logic di, input logic rw, input logic [1:0] cs,
                                    input logic [7:0] dout);
        bus_cyc_t c;
        c.di   = di;
        c.rw   = rw;
        c.cs   = cs;
        c.oe   = !rw;
        c.dout = rw ? 8'h00 : dout;
        return c;
    endfunction

    // Panel: logs every enable pulse and presents the next queued byte on reads.
    initial begin : panel
        logic en_prev;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (lif.lcd_en && !en_prev) begin
                obs_q.push_back(mk(lif.lcd_di, lif.lcd_rw, lif.lcd_cs,
                                   lif.lcd_data_oe ? lif.lcd_data_out : 8'h00));
                en_cyc_q.push_back(cyc);
                if (lif.lcd_rw) lif.lcd_data_in = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hEE;
            end
            en_prev = lif.lcd_en;
        end
    end

    // g: cycles bus_gnt stays low after acceptance; b1/b2: busy polls before page/col.
    task automatic run_txn(input bit typ, input logic [1:0] cs, input logic [2:0] pg,
                           input logic [5:0] col, input int g, input int b1, input int b2,
                           input logic [7:0] val, input logic [7:0] dummy);
        bus_cyc_t exp_q[$];
        bit       valid, timeout, quiet;
        int       k, d, nbus, exp_d;
        valid   = (cs == 2'b01) || (cs == 2'b10);
        timeout = 1'b0;
        quiet   = 1'b1;
        resp_q.delete();
        obs_q.delete();
        en_cyc_q.delete();
        if (valid && !typ) begin
            resp_q.push_back(val);
            exp_q.push_back(mk(1'b0, 1'b1, cs, 8'h00));
        end else if (valid) begin
`ifdef BUSY_POLL_EN
            for (int ph = 0; ph < 2; ph++) begin
                int nb;
                nb = (ph == 0) ? b1 : b2;
                if (!timeout) begin
                    for (int i = 0; i < nb && i < BusyTimeout; i++) begin
                        resp_q.push_back(8'h80 | 8'($urandom));
                        exp_q.push_back(mk(1'b0, 1'b1, cs, 8'h00));
                    end
                    if (nb >= BusyTimeout) begin
                        timeout = 1'b1;
                    end else begin
                        resp_q.push_back(8'h7F & 8'($urandom));
                        exp_q.push_back(mk(1'b0, 1'b1, cs, 8'h00));
                        exp_q.push_back(mk(1'b0, 1'b0, cs,
                                           (ph == 0) ? (8'hB8 | 8'(pg)) : (8'h40 | 8'(col))));
                    end
                end
            end
`else
            if (b1 + b2 < 0) timeout = 1'b1;
            exp_q.push_back(mk(1'b0, 1'b0, cs, 8'hB8 | 8'(pg)));
            exp_q.push_back(mk(1'b0, 1'b0, cs, 8'h40 | 8'(col)));
`endif
            if (!timeout) begin
                resp_q.push_back(dummy);
                resp_q.push_back(val);
                exp_q.push_back(mk(1'b1, 1'b1, cs, 8'h00));
                exp_q.push_back(mk(1'b1, 1'b1, cs, 8'h00));
            end
        end
        nbus = exp_q.size();

        lif.bus_gnt  = (g == 0);
        lif.req_type = typ;
        lif.req_cs   = cs;
        lif.req_page = pg;
        lif.req_col  = col;
        lif.req      = 1'b1;
        @(negedge clk);
        k = cyc;
        if (valid) lif.req = 1'b0;
        else lif.req_cs = 2'b01;  // valid request arriving while the rejection completes
        d = -1;
        for (int t = 0; t < 300; t++) begin
            if (t == 1) lif.req = 1'b0;
            if (lif.done) begin
                d = cyc;
                break;
            end
            if (!lif.bus_gnt && t >= 1 &&
                !(lif.bus_req && !lif.lcd_en && lif.lcd_cs == 2'b00)) quiet = 1'b0;
            if (t >= g) lif.bus_gnt = 1'b1;
            @(negedge clk);
        end
        lif.req = 1'b0;

        exp_d = valid ? (k + g + 2 + 3 * nbus) : (k + 1);
        check("done_cycle", d, exp_d);
        check("err", lif.err, !valid || timeout);
        if (valid && !timeout) exp_rd = val;
        check("rd_data", lif.rd_data, exp_rd);
        if (!timeout) check("busy_at_done", lif.busy, valid);
        check("bus_cycle_count", obs_q.size(), nbus);
        for (int i = 0; i < nbus && i < obs_q.size(); i++)
            check($sformatf("bus_cycle%0d", i), obs_q[i], exp_q[i]);
        if (valid) check("en_rise_cycle", (en_cyc_q.size() != 0) ? en_cyc_q[0] : -1, k + g + 3);
        check("gnt_wait_quiet", quiet, 1'b1);
        @(negedge clk);
        check("release", {lif.busy, lif.bus_req, lif.done, lif.lcd_en, lif.lcd_cs}, 0);
    endtask

    task automatic reset_mid_read();
        bit seen;
        seen = 1'b0;
        resp_q.delete();
        lif.bus_gnt  = 1'b1;
        lif.req_type = 1'b1;
        lif.req_cs   = 2'b10;
        lif.req_page = 3'd1;
        lif.req_col  = 6'd2;
        lif.req      = 1'b1;
        @(negedge clk);
        lif.req = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (lif.lcd_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("en_before_reset", seen, 1'b1);
        rst = 1'b1;
        #1;
        check("reset_mid_read", {lif.lcd_en, lif.lcd_cs, lif.lcd_data_oe, lif.busy, lif.bus_req,
                                 lif.done, lif.rd_data}, 0);
        exp_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        en_cyc_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        lif.req         = 1'b0;
        lif.req_type    = 1'b0;
        lif.req_cs      = 2'b00;
        lif.req_page    = 3'd0;
        lif.req_col     = 6'd0;
        lif.bus_gnt     = 1'b0;
        lif.lcd_data_in = 8'h00;
        exp_rd          = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {lif.busy, lif.done, lif.err, lif.rd_data, lif.bus_req, lif.lcd_en,
                              lif.lcd_cs, lif.lcd_data_oe, lif.lcd_di, lif.lcd_rw,
                              lif.lcd_data_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 2'b01, 3'd0, 6'd0, 0, 0, 0, 8'h20, 8'hFF);
        run_txn(1'b1, 2'b10, 3'd5, 6'd37, 0, 0, 0, 8'h3C, 8'hFF);
        reset_mid_read();
        run_txn(1'b0, 2'b10, 3'd0, 6'd0, 0, 0, 0, 8'h5A, 8'hFF);
        run_txn(1'b1, 2'b01, 3'd3, 6'd12, 10, 0, 0, 8'hA7, 8'h11);
        run_txn(1'b0, 2'b11, 3'd0, 6'd0, 0, 0, 0, 8'h99, 8'hFF);
        run_txn(1'b1, 2'b00, 3'd7, 6'd63, 0, 0, 0, 8'h66, 8'hFF);
`ifdef BUSY_POLL_EN
        run_txn(1'b1, 2'b01, 3'd2, 6'd9, 0, 3, 0, 8'h44, 8'hFF);
        run_txn(1'b1, 2'b10, 3'd7, 6'd63, 0, BusyTimeout, 0, 8'h55, 8'hFF);
`endif
        for (int n = 0; n < 40; n++) begin
            logic [1:0] cs;
            case ($urandom_range(0, 5))
                0:       cs = 2'b00;
                1:       cs = 2'b11;
                2, 3:    cs = 2'b01;
                default: cs = 2'b10;
            endcase
            run_txn(1'($urandom), cs, 3'($urandom), 6'($urandom),
                    ((cs == 2'b01) || (cs == 2'b10)) ? int'($urandom_range(0, 4)) : 0,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
